radius_band_calc: RTL and testbench
===================================

// Module: radius_band_calc
// PURPOSE
//  Handshaked, parametrised distance-to-band engine for the spiral/ring renderer.
//  Folds pixel coordinates about screen centre and computes a distance per request:
//  Euclidean (exact bit-serial integer sqrt), Manhattan or Chebyshev.
//  Emits a wrapped band index with a runtime phase offset, for animation.
//  A single shared multiplier is time-multiplexed over squaring; sits between pixel counters and colour mapper.
// PARAMETERS
//  COORD_W     10  coordinate width; MSB selects fold (half-screen)
//  DROP_BITS   2   LSBs discarded after fold; N = COORD_W-1-DROP_BITS magnitude bits
//  BAND_W      4   band index width; band wraps mod 2^BAND_W
//  BAND_SHIFT  0   right shift applied to distance before banding
//  (derived) DIST_W = N+1; SUM_W = 2*DIST_W (square-sum, zero-padded)
// PORTS
//  clk          in   1        clock
//  rst_n        in   1        async active-low reset
//  in_valid     in   1        request valid
//  in_ready     out  1        engine idle, request accepted when in_valid&in_ready
//  x_pos        in   COORD_W  pixel x
//  y_pos        in   COORD_W  pixel y
//  mode         in   2        0 Euclid, 1 Manhattan, 2 Chebyshev, 3 reserved (=Euclid)
//  band_offset  in   BAND_W   phase added to band, sampled with request
//  out_valid    out  1        result valid, held until out_ready
//  out_ready    in   1        consumer accepts result
//  out_dist     out  DIST_W   raw distance d
//  out_band     out  BAND_W   ((d >> BAND_SHIFT) + band_offset) mod 2^BAND_W
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE, in_ready=1, out_valid=0, out_dist=0, out_band=0, internal regs 0.
//  Fold: n = pos[COORD_W-1] ? ~pos[COORD_W-2:DROP_BITS] : pos[COORD_W-2:DROP_BITS] (N bits, unsigned).
//  On accept, register nx, ny, mode, band_offset; later input changes have no effect.
//  FSM: IDLE -> (accept) SQX | DIST; SQX -> SQY -> SQRT(DIST_W cycles) -> DONE; DIST -> DONE;
//       DONE -> IDLE when out_ready. in_ready=1 only in IDLE; out_valid=1 only in DONE.
//  SQX: acc <= nx*nx. SQY: acc <= acc + ny*ny (SUM_W bits, no overflow possible).
//  SQRT: restoring, 2 sum bits/cycle MSB first: rem'=(rem<<2)|next2; t=(root<<2)|1;
//        rem'>=t ? (rem<=rem'-t, root<=(root<<1)|1) : (rem<=rem', root<=root<<1). d=floor(sqrt(acc)).
//  DIST: Manhattan d = nx+ny (DIST_W bits); Chebyshev d = max(nx,ny) zero-extended.
//  Latency, accept at edge k: Euclid out_valid rises after edge k+2+DIST_W (k+10 default);
//        Manhattan/Chebyshev after edge k+1.
//  out_dist/out_band registered on the DONE entry edge; stable while out_valid & !out_ready.
//  Same-cycle out_valid&out_ready: returns to IDLE; next request accepted no earlier than following edge.
//  Band addition truncates (wrap), no saturation. Mode 3 behaves exactly as mode 0.
//  rst_n low mid-computation: abort immediately, outputs to reset values, no result emitted.
// TESTING
//  1 Euclid: x_pos=12,y_pos=16 (nx=3,ny=4), offset 0 -> out_dist=5, out_band=5, valid at k+10.
//  2 Fold/extremes: x_pos=10'h3FF,y_pos=0 -> d=0,band=0; x_pos=y_pos=508 (127,127) -> d=179, band=3.
//  3 Modes: 127,127 Manhattan -> d=254, band=14 at k+1; 3,4 Chebyshev -> d=4, band=4; mode 3 = mode 0.
//  4 Offset wrap: nx=3,ny=4 Euclid, band_offset=15 -> band=4; BAND_SHIFT=1 build -> band=(2+15)%16=1.
//  5 Backpressure: out_ready=0 for 20 cycles -> out_valid, out_dist, out_band stable, in_ready=0,
//    new in_valid ignored; out_ready=1 -> IDLE next edge, back-to-back requests each produce one result.
//  6 Reset: assert rst_n=0 during SQRT -> out_valid=0, in_ready=1 asynchronously; fresh request correct.
//  Sweep: all nx,ny in 0..127 x 3 modes against a reference model; no X on outputs after reset.

Source files
------------

// File: rtl/radius_band_calc.sv
// Distance-to-band engine: folds pixel coordinates about the screen centre, computes a
// Euclidean (bit-serial isqrt), Manhattan or Chebyshev distance, and emits a phased band index.
module radius_band_calc #(
  parameter int COORD_W    = 10,
  parameter int DROP_BITS  = 2,
  parameter int BAND_W     = 4,
  parameter int BAND_SHIFT = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [COORD_W-1:0] x_pos,
  input  logic [COORD_W-1:0] y_pos,
  input  logic [1:0]         mode,
  input  logic [BAND_W-1:0]  band_offset,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COORD_W-1-DROP_BITS:0] out_dist,
  output logic [BAND_W-1:0]  out_band
);
  localparam int N      = COORD_W - 1 - DROP_BITS;
  localparam int DIST_W = N + 1;
  localparam int SUM_W  = 2 * DIST_W;
  localparam int RW     = DIST_W + 3;
  localparam int CW     = $clog2(DIST_W + 1);

  typedef enum logic [2:0] {IDLE, SQX, SQY, SQRT, DIST, DONE} state_t;

  state_t              state, state_nx;
  logic [N-1:0]        nx, ny;
  logic [1:0]          mode_r;
  logic [BAND_W-1:0]   off_r;
  logic [SUM_W-1:0]    acc;
  logic [RW-1:0]       rem;
  logic [DIST_W-1:0]   root;
  logic [CW-1:0]       cnt;

  function automatic logic [N-1:0] fold(input logic [COORD_W-1:0] p);
    return p[COORD_W-1] ? ~p[COORD_W-2:DROP_BITS] : p[COORD_W-2:DROP_BITS];
  endfunction

  function automatic logic [BAND_W-1:0] band_of(input logic [DIST_W-1:0] d,
                                                 input logic [BAND_W-1:0] off);
    logic [DIST_W+BAND_W-1:0] e;
    e = {{BAND_W{1'b0}}, d} >> BAND_SHIFT;
    return e[BAND_W-1:0] + off;
  endfunction

  // One shared squarer: nx in SQX, ny in SQY.
  logic [N-1:0]   mul_a;
  logic [2*N-1:0] prod;
  assign mul_a = (state == SQX) ? nx : ny;
  assign prod  = {{N{1'b0}}, mul_a} * {{N{1'b0}}, mul_a};

  // Restoring square-root step, consuming the top two bits of acc each cycle.
  logic [RW-1:0]     rem_sh, trial, rem_nx;
  logic [DIST_W-1:0] root_nx;
  logic              ge;
  assign rem_sh  = {rem[RW-3:0], acc[SUM_W-1 -: 2]};
  assign trial   = {{(RW-DIST_W-2){1'b0}}, root, 2'b01};
  assign ge      = rem_sh >= trial;
  assign rem_nx  = ge ? rem_sh - trial : rem_sh;
  assign root_nx = {root[DIST_W-2:0], ge};

  logic [DIST_W-1:0] man_d, cheb_d, alt_d;
  assign man_d  = {1'b0, nx} + {1'b0, ny};
  assign cheb_d = {1'b0, (nx > ny) ? nx : ny};
  assign alt_d  = (mode_r == 2'd1) ? man_d : cheb_d;

  logic last_step;
  assign last_step = (cnt == CW'(DIST_W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (in_valid) state_nx = (mode == 2'd1 || mode == 2'd2) ? DIST : SQX;
      SQX:  state_nx = SQY;
      SQY:  state_nx = SQRT;
      SQRT: if (last_step) state_nx = DONE;
      DIST: state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nx <= '0; ny <= '0; mode_r <= '0; off_r <= '0;
      acc <= '0; rem <= '0; root <= '0; cnt <= '0;
      out_dist <= '0; out_band <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          nx     <= fold(x_pos);
          ny     <= fold(y_pos);
          mode_r <= mode;
          off_r  <= band_offset;
          rem    <= '0;
          root   <= '0;
          cnt    <= '0;
        end
        SQX: acc <= {{(SUM_W-2*N){1'b0}}, prod};
        SQY: acc <= acc + {{(SUM_W-2*N){1'b0}}, prod};
        SQRT: begin
          acc  <= acc << 2;
          rem  <= rem_nx;
          root <= root_nx;
          cnt  <= cnt + 1'b1;
          if (last_step) begin
            out_dist <= root_nx;
            out_band <= band_of(root_nx, off_r);
          end
        end
        DIST: begin
          out_dist <= alt_d;
          out_band <= band_of(alt_d, off_r);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_radius_band_calc.sv
// Directed bench for radius_band_calc: default build plus a BAND_SHIFT=1 build on shared inputs.
module tb_radius_band_calc;
  logic       clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [9:0] x_pos = '0, y_pos = '0;
  logic [1:0] mode = '0;
  logic [3:0] band_offset = '0;
  logic       in_ready, out_valid, in_ready_s1, out_valid_s1;
  logic [7:0] out_dist, out_dist_s1;
  logic [3:0] out_band, out_band_s1;
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  radius_band_calc dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x_pos(x_pos), .y_pos(y_pos), .mode(mode), .band_offset(band_offset),
    .out_valid(out_valid), .out_ready(out_ready), .out_dist(out_dist), .out_band(out_band));

  radius_band_calc #(.BAND_SHIFT(1)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s1),
    .x_pos(x_pos), .y_pos(y_pos), .mode(mode), .band_offset(band_offset),
    .out_valid(out_valid_s1), .out_ready(out_ready), .out_dist(out_dist_s1), .out_band(out_band_s1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [9:0] x, input logic [9:0] y, input logic [1:0] m,
                      input logic [3:0] off, input string tag);
    @(negedge clk);
    chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; x_pos = x; y_pos = y; mode = m; band_offset = off;
    @(posedge clk); #1;
    in_valid = 1'b0;
    // scramble inputs after accept; the engine must have captured them
    x_pos = 10'($urandom); y_pos = 10'($urandom);
    mode = 2'($urandom); band_offset = 4'($urandom);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (out_valid !== 1'b1 && lat < 40);
  endtask

  task automatic run(input logic [9:0] x, input logic [9:0] y, input logic [1:0] m,
                     input logic [3:0] off, input int ed, input int eb, input int eb1,
                     input int elat, input string tag);
    int lat;
    send(x, y, m, off, tag);
    wait_out(lat);
    chk({tag, " latency"}, 32'(lat), 32'(elat));
    chk({tag, " dist"}, 32'(out_dist), 32'(ed));
    chk({tag, " band"}, 32'(out_band), 32'(eb));
    chk({tag, " valid_s1"}, 32'(out_valid_s1), 32'd1);
    chk({tag, " band_s1"}, 32'(out_band_s1), 32'(eb1));
    @(posedge clk); #1;
    chk({tag, " released"}, 32'(out_valid), 32'd0);
  endtask

  function automatic int isqrt(input int s);
    int r = 0;
    while ((r + 1) * (r + 1) <= s) r++;
    return r;
  endfunction

  initial begin
    int lat;
    #2;
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_dist", 32'(out_dist), 32'd0);
    chk("rst out_band", 32'(out_band), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run(10'd12, 10'd16, 2'd0, 4'd0, 5, 5, 2, 10, "euclid34");
    run(10'h3FF, 10'd0, 2'd0, 4'd0, 0, 0, 0, 10, "fold_zero");
    run(10'd508, 10'd508, 2'd0, 4'd0, 179, 3, 9, 10, "euclid_max");
    run(10'd508, 10'd508, 2'd1, 4'd0, 254, 14, 15, 1, "manhattan_max");
    run(10'd12, 10'd16, 2'd2, 4'd0, 4, 4, 2, 1, "cheby34");
    run(10'd12, 10'd16, 2'd3, 4'd0, 5, 5, 2, 10, "mode3");
    run(10'd12, 10'd16, 2'd0, 4'd15, 5, 4, 1, 10, "offset_wrap");
    // folded upper half: x=1000 -> ~(1000[8:2]=122) = 5, y=600 -> ~(22) = 105
    run(10'd1000, 10'd600, 2'd2, 4'd7, 105, 0, 11, 1, "cheby_fold");

    // backpressure: result held, new requests ignored
    out_ready = 1'b0;
    send(10'd12, 10'd16, 2'd0, 4'd15, "bp");
    wait_out(lat);
    chk("bp latency", 32'(lat), 32'd10);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_valid = 1'b1; x_pos = 10'd508; y_pos = 10'd508; mode = 2'd1; band_offset = 4'd3;
      @(posedge clk); #1;
      chk("bp valid", 32'(out_valid), 32'd1);
      chk("bp dist", 32'(out_dist), 32'd5);
      chk("bp band", 32'(out_band), 32'd4);
      chk("bp in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp release valid", 32'(out_valid), 32'd0);
    chk("bp release in_ready", 32'(in_ready), 32'd1);
    run(10'd508, 10'd508, 2'd1, 4'd3, 254, 1, 2, 1, "b2b_a");
    run(10'd12, 10'd16, 2'd0, 4'd1, 5, 6, 3, 10, "b2b_b");

    // reset during the square-root phase
    send(10'd508, 10'd508, 2'd0, 4'd0, "rst_mid");
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid in_ready", 32'(in_ready), 32'd1);
    chk("rst_mid out_dist", 32'(out_dist), 32'd0);
    chk("rst_mid out_band", 32'(out_band), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(10'd12, 10'd16, 2'd0, 4'd0, 5, 5, 2, 10, "post_rst");

    // reference-model sweep over random and extreme magnitudes, with random folding
    for (int i = 0; i < 30; i++) begin
      logic [6:0] a, b;
      logic       fa, fb;
      logic [3:0] off;
      logic [1:0] m;
      logic [9:0] x, y;
      int d;
      a = (i == 0) ? 7'd127 : (i == 1) ? 7'd0 : 7'($urandom);
      b = (i == 0) ? 7'd127 : (i == 1) ? 7'd127 : 7'($urandom);
      fa = 1'($urandom); fb = 1'($urandom);
      off = 4'($urandom);
      m = 2'(i % 3);
      x = {fa, fa ? ~a : a, 2'($urandom)};
      y = {fb, fb ? ~b : b, 2'($urandom)};
      if (m == 2'd0)      d = isqrt(int'(a) * int'(a) + int'(b) * int'(b));
      else if (m == 2'd1) d = int'(a) + int'(b);
      else                d = (a > b) ? int'(a) : int'(b);
      run(x, y, m, off, d, (d + int'(off)) % 16, ((d >> 1) + int'(off)) % 16,
          (m == 2'd0) ? 10 : 1, "sweep");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
